// File: rtl/cca_pkg.sv
// rtl/cca_pkg.sv - shared FSM state encoding and busy_cause bit positions for cca_detect
package cca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TX_TAIL = 2'd2,
    ST_SETTLE  = 2'd3
  } cca_state_t;

  localparam int CAUSE_ENERGY = 0;
  localparam int CAUSE_DEMOD  = 1;
  localparam int CAUSE_TX     = 2;

  localparam int TIMER_WIDTH = 9;

endpackage

// File: rtl/cca_energy_det.sv
// rtl/cca_energy_det.sv - RSSI energy flag with hysteresis; set above threshold, clear below threshold minus hysteresis
module cca_energy_det #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rssi_half_db,
  input  logic             rssi_half_db_valid,
  input  logic [WIDTH-1:0] rssi_th,
  input  logic [4:0]       rssi_hyst,
  output logic             energy_busy
);

  logic signed [WIDTH:0] rssi_ext;
  logic signed [WIDTH:0] th_ext;
  logic signed [WIDTH:0] low_ext;

  // One extra bit keeps th - hyst from wrapping when th sits near the negative limit.
  assign rssi_ext = $signed({rssi_half_db[WIDTH-1], rssi_half_db});
  assign th_ext   = $signed({rssi_th[WIDTH-1], rssi_th});
  assign low_ext  = th_ext - $signed({{(WIDTH-4){1'b0}}, rssi_hyst});

  always_ff @(posedge clk) begin
    if (rst) begin
      energy_busy <= 1'b0;
    end else if (rssi_half_db_valid) begin
      if (rssi_ext > th_ext) begin
        energy_busy <= 1'b1;
      end else if (rssi_ext < low_ext) begin
        energy_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cca_detect.sv
// rtl/cca_detect.sv - clear channel assessment: busy sources, post-TX tail and settle qualification, busy-time statistics
module cca_detect
  import cca_pkg::*;
#(
  parameter int RSSI_HALF_DB_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tsf_pulse_1M,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                          rssi_half_db_valid,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
  input  logic [4:0]                    rssi_hyst,
  input  logic                          demod_is_ongoing,
  input  logic                          tx_rf_is_ongoing,
  input  logic [6:0]                    tx_tail_us,
  input  logic [7:0]                    settle_us,
  input  logic                          force_busy,
  input  logic                          force_idle,
  input  logic                          busy_us_clear,
  output logic                          ch_idle,
  output logic [2:0]                    busy_cause,
  output logic [31:0]                   busy_us_count
);

  cca_state_t             state;
  cca_state_t             next_state;
  logic [TIMER_WIDTH-1:0] us_timer;
  logic [TIMER_WIDTH-1:0] timer_next;
  logic                   tx_seen;
  logic                   tx_seen_next;
  logic                   energy_busy;
  logic                   src;
  logic                   ch_idle_next;
  logic [2:0]             cause_next;

  cca_energy_det #(
    .WIDTH(RSSI_HALF_DB_WIDTH)
  ) u_energy_det (
    .clk               (clk),
    .rst               (rst),
    .rssi_half_db      (rssi_half_db),
    .rssi_half_db_valid(rssi_half_db_valid),
    .rssi_th           (rssi_th),
    .rssi_hyst         (rssi_hyst),
    .energy_busy       (energy_busy)
  );

  assign src = energy_busy | demod_is_ongoing | tx_rf_is_ongoing;

  always_comb begin
    next_state = state;
    timer_next = us_timer;
    unique case (state)
      ST_IDLE: begin
        if (src) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        if (!src) begin
          if (tx_seen) begin
            next_state = ST_TX_TAIL;
            timer_next = {2'b00, tx_tail_us};
          end else begin
            next_state = ST_SETTLE;
            timer_next = {1'b0, settle_us};
          end
        end
      end
      ST_TX_TAIL: begin
        if (src) begin
          next_state = ST_BUSY;
        end else if (us_timer == '0) begin
          next_state = ST_SETTLE;
          timer_next = {1'b0, settle_us};
        end else if (tsf_pulse_1M) begin
          timer_next = us_timer - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (src) begin
          next_state = ST_BUSY;
        end else if (us_timer == '0) begin
          next_state = ST_IDLE;
        end else if (tsf_pulse_1M) begin
          timer_next = us_timer - 1'b1;
        end
      end
      default: next_state = ST_BUSY;
    endcase
  end

  // tx_seen spans one busy episode, including any TX_TAIL that bounced back into BUSY.
  always_comb begin
    tx_seen_next = tx_seen;
    if (state == ST_BUSY && tx_rf_is_ongoing) begin
      tx_seen_next = 1'b1;
    end else if (next_state == ST_IDLE || next_state == ST_SETTLE) begin
      tx_seen_next = 1'b0;
    end
  end

  always_comb begin
    ch_idle_next = (next_state == ST_IDLE);
    if (force_busy) begin
      ch_idle_next = 1'b0;
    end else if (force_idle) begin
      ch_idle_next = 1'b1;
    end
  end

  always_comb begin
    cause_next               = '0;
    cause_next[CAUSE_ENERGY] = energy_busy;
    cause_next[CAUSE_DEMOD]  = demod_is_ongoing;
    cause_next[CAUSE_TX]     = tx_rf_is_ongoing;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BUSY;
      us_timer   <= '0;
      tx_seen    <= 1'b0;
      ch_idle    <= 1'b0;
      busy_cause <= '0;
    end else begin
      state      <= next_state;
      us_timer   <= timer_next;
      tx_seen    <= tx_seen_next;
      ch_idle    <= ch_idle_next;
      busy_cause <= cause_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || busy_us_clear) begin
      busy_us_count <= '0;
    end else if (tsf_pulse_1M && !ch_idle && busy_us_count != 32'hFFFF_FFFF) begin
      busy_us_count <= busy_us_count + 32'd1;
    end
  end

endmodule
